// File: rtl/dct_1d_row_sequencer_pkg.sv
// Shared definitions for the 1-D DCT row/column sequencers: FSM encoding,
// default timing constants and a counter-width helper.
package dct_1d_row_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } dct_state_e;

  localparam int DCT_LOAD_LAT       = 1;
  localparam int DCT_CALC_STEPS     = 4;
  localparam int DCT_SEND_CYCLES    = 8;
  localparam int DCT_ROWS_PER_BLOCK = 8;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dct_1d_row_sequencer_if.sv
// Control bundle between the pixel receiver / datapath / serialiser and the
// row sequencer. The sequencer side uses the slave modport.
interface dct_1d_row_sequencer_if;
  logic       Start_Calc;
  logic [1:0] Sele;
  logic       Calc_En;
  logic       Acc_Clr;
  logic       End_Calc;
  logic       Busy;
  logic       Block_Done;
  logic       Overrun;

  modport master (
    output Start_Calc,
    input  Sele, Calc_En, Acc_Clr, End_Calc, Busy, Block_Done, Overrun
  );

  modport slave (
    input  Start_Calc,
    output Sele, Calc_En, Acc_Clr, End_Calc, Busy, Block_Done, Overrun
  );
endinterface

// File: rtl/dct_send_slot_tracker.sv
// Tracks how many serialiser cycles remain after an End_Calc and reports,
// one cycle ahead, whether the output slot will be free.
module dct_send_slot_tracker
  import dct_1d_row_sequencer_pkg::*;
#(
  parameter int SEND_CYCLES = DCT_SEND_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic end_calc,          // registered End_Calc as seen by the serialiser
  output logic slot_free_next,    // slot free in the coming cycle
  output logic send_active_next   // send window active in the coming cycle
);

  localparam int REM_W = cnt_width(SEND_CYCLES);

  logic [REM_W-1:0] send_rem_q, send_rem_d;

  always_comb begin
    send_rem_d = send_rem_q;
    if (end_calc) begin
      send_rem_d = REM_W'(SEND_CYCLES);
    end else if (send_rem_q != '0) begin
      send_rem_d = send_rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_rem_q <= '0;
    end else begin
      send_rem_q <= send_rem_d;
    end
  end

  // The last shift cycle may overlap the next row's End_Calc.
  assign slot_free_next   = (send_rem_d <= REM_W'(1));
  assign send_active_next = (send_rem_d != '0);

endmodule

// File: rtl/dct_1d_row_sequencer.sv
// Row-pass control FSM for the 1-D DCT: waits for the butterfly stage, steps the
// shared multiplier through its Sele phases and hands each row to the serialiser.
module dct_1d_row_sequencer
  import dct_1d_row_sequencer_pkg::*;
#(
  parameter int LOAD_LAT       = DCT_LOAD_LAT,
  parameter int CALC_STEPS     = DCT_CALC_STEPS,
  parameter int SEND_CYCLES    = DCT_SEND_CYCLES,
  parameter int ROWS_PER_BLOCK = DCT_ROWS_PER_BLOCK
) (
  input  logic                     Clock,
  input  logic                     Reset,
  dct_1d_row_sequencer_if.slave    bus
);

  localparam int LAT_W  = cnt_width(LOAD_LAT - 1);
  localparam int STEP_W = cnt_width(CALC_STEPS - 1);
  localparam int ROW_W  = cnt_width(ROWS_PER_BLOCK - 1);

  dct_state_e        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [1:0]        sele_q, sele_d;
  logic              calc_en_q, calc_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              end_calc_q, end_calc_d;
  logic              busy_q, busy_d;
  logic              block_done_q, block_done_d;
  logic              overrun_q, overrun_d;
  logic              slot_free_next;
  logic              send_active_next;

  dct_send_slot_tracker #(
    .SEND_CYCLES (SEND_CYCLES)
  ) u_slot (
    .clk              (Clock),
    .rst              (Reset),
    .end_calc         (end_calc_q),
    .slot_free_next   (slot_free_next),
    .send_active_next (send_active_next)
  );

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    step_cnt_d = step_cnt_q;
    row_cnt_d  = row_cnt_q;
    overrun_d  = overrun_q | (bus.Start_Calc && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start_Calc) begin
          state_d   = ST_LOAD;
          lat_cnt_d = LAT_W'(LOAD_LAT - 1);
        end
      end
      ST_LOAD: begin
        if (lat_cnt_q == '0) begin
          state_d    = ST_CALC;
          step_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_CALC: begin
        if (step_cnt_q == STEP_W'(CALC_STEPS - 1)) begin
          state_d = ST_ISSUE;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      // End_Calc is registered, so seeing it here means the row was issued.
      ST_ISSUE, ST_WAIT: begin
        state_d = end_calc_q ? ST_IDLE : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    calc_en_d    = (state_d == ST_CALC);
    sele_d       = calc_en_d ? 2'(step_cnt_d) : 2'd0;
    acc_clr_d    = calc_en_d && (step_cnt_d == '0);
    end_calc_d   = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) && slot_free_next;
    block_done_d = end_calc_d && (row_cnt_q == ROW_W'(ROWS_PER_BLOCK - 1));
    busy_d       = (state_d != ST_IDLE) || send_active_next;

    if (end_calc_d) begin
      row_cnt_d = (row_cnt_q == ROW_W'(ROWS_PER_BLOCK - 1)) ? '0 : row_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      step_cnt_q   <= '0;
      row_cnt_q    <= '0;
      sele_q       <= 2'd0;
      calc_en_q    <= 1'b0;
      acc_clr_q    <= 1'b0;
      end_calc_q   <= 1'b0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      step_cnt_q   <= step_cnt_d;
      row_cnt_q    <= row_cnt_d;
      sele_q       <= sele_d;
      calc_en_q    <= calc_en_d;
      acc_clr_q    <= acc_clr_d;
      end_calc_q   <= end_calc_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.Sele       = sele_q;
  assign bus.Calc_En    = calc_en_q;
  assign bus.Acc_Clr    = acc_clr_q;
  assign bus.End_Calc   = end_calc_q;
  assign bus.Busy       = busy_q;
  assign bus.Block_Done = block_done_q;
  assign bus.Overrun    = overrun_q;

endmodule

// File: tb/tb_dct_1d_row_sequencer.sv
// Bench for dct_1d_row_sequencer: directed scenarios followed by random traffic,
// each cycle compared against a row-level timing model.
module tb_dct_1d_row_sequencer;
  import dct_1d_row_sequencer_pkg::*;

  localparam int LAT   = DCT_LOAD_LAT;
  localparam int STEPS = DCT_CALC_STEPS;
  localparam int SEND  = DCT_SEND_CYCLES;
  localparam int ROWS  = DCT_ROWS_PER_BLOCK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_1d_row_sequencer_if bus ();

  dct_1d_row_sequencer #(
    .LOAD_LAT       (LAT),
    .CALC_STEPS     (STEPS),
    .SEND_CYCLES    (SEND),
    .ROWS_PER_BLOCK (ROWS)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;
  bit checking = 1'b0;

  // Row-level model: one in-flight row (start cycle, End_Calc cycle) plus history.
  bit have_row  = 1'b0;
  int row_t     = 0;
  int row_e     = 0;
  int last_end  = -1000;
  int rows_done = 0;
  bit ovr       = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs for this cycle, then apply inputs and advance the model.
  task automatic step(input bit start, input bit r);
    int  k;
    bit  in_fsm, calc, e_end, send, ended;
    @(posedge clk);
    #1;
    in_fsm = have_row && (cyc >= row_t + 1) && (cyc <= row_e);
    k      = cyc - (row_t + 1 + LAT);
    calc   = have_row && (k >= 0) && (k < STEPS);
    e_end  = have_row && (cyc == row_e);
    send   = (cyc >= last_end + 1) && (cyc <= last_end + SEND);
    if (checking) begin
      check("sele",       8'(bus.Sele),       calc ? 8'(k) : 8'd0);
      check("calc_en",    8'(bus.Calc_En),    8'(calc));
      check("acc_clr",    8'(bus.Acc_Clr),    8'(calc && k == 0));
      check("end_calc",   8'(bus.End_Calc),   8'(e_end));
      check("busy",       8'(bus.Busy),       8'(in_fsm || send));
      check("block_done", 8'(bus.Block_Done), 8'(e_end && (rows_done % ROWS == ROWS - 1)));
      check("overrun",    8'(bus.Overrun),    8'(ovr));
    end
    bus.Start_Calc = start;
    rst            = r;
    if (r) begin
      have_row  = 1'b0;
      last_end  = -1000;
      rows_done = 0;
      ovr       = 1'b0;
    end else begin
      ended = e_end;
      if (ended) begin
        rows_done++;
        last_end = cyc;
        have_row = 1'b0;
      end
      if (start) begin
        if (in_fsm) begin
          ovr = 1'b1;
        end else begin
          have_row = 1'b1;
          row_t    = cyc;
          row_e    = (cyc + 1 + LAT + STEPS > last_end + SEND) ?
                     cyc + 1 + LAT + STEPS : last_end + SEND;
        end
      end
    end
    cyc++;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step(1'b0, 1'b0);
  endtask

  task automatic reset_scenario();
    base = cyc;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checking = 1'b1;
  endtask

  initial begin
    bus.Start_Calc = 1'b0;

    // Single row
    reset_scenario();
    go_to(base + 10); step(1'b1, 1'b0);
    go_to(base + 30);

    // Full rate: eight rows, eight cycles apart, Block_Done on the last
    reset_scenario();
    for (int i = 0; i < ROWS; i++) begin
      go_to(base + 10 + 8 * i);
      step(1'b1, 1'b0);
    end
    go_to(base + 95);

    // Slot stall: second row ready before the send window has drained
    reset_scenario();
    go_to(base + 10); step(1'b1, 1'b0);
    go_to(base + 17); step(1'b1, 1'b0);
    go_to(base + 45);

    // Overrun mid-CALC
    reset_scenario();
    go_to(base + 10); step(1'b1, 1'b0);
    go_to(base + 13); step(1'b1, 1'b0);
    go_to(base + 40);

    // Reset mid-operation, then a fresh row
    reset_scenario();
    go_to(base + 10); step(1'b1, 1'b0);
    go_to(base + 13); step(1'b0, 1'b1);
    go_to(base + 20); step(1'b1, 1'b0);
    go_to(base + 45);

    // Start with reset together; Start_Calc in the ISSUE cycle
    reset_scenario();
    go_to(base + 10); step(1'b1, 1'b1);
    go_to(base + 20); step(1'b1, 1'b0);
    go_to(base + 26); step(1'b1, 1'b0);
    go_to(base + 50);

    // Random traffic with occasional resets
    reset_scenario();
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
    end
    go_to(cyc + 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
